branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the fetch stage: direct-mapped branch history table (2-bit saturating counters) plus branch target buffer.
- Gives the IF stage a combinational taken/target prediction for the current PC.
- Updated from the ID stage when a B/BR instruction resolves; produces the branch_mispredicted/branch_taken pair used by hazard detection to flush IF/ID.

Parameters:
ADDR_W, 16, PC width in bits (byte address; instructions are 2-byte aligned)
NUM_ENTRIES, 8, table entries; power of two, >= 2; IDX_W = log2(NUM_ENTRIES)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
IF_PC  in  ADDR_W  PC of the instruction being fetched
predicted_taken  out  1  IF prediction: branch will be taken
predicted_target  out  ADDR_W  IF predicted target (valid only when predicted_taken=1)
ID_PC  in  ADDR_W  PC of the instruction in ID
ID_is_branch  in  1  ID instruction is B or BR and its outcome is resolved this cycle
ID_actual_taken  in  1  resolved branch direction
ID_actual_target  in  ADDR_W  resolved branch target address
ID_predicted_taken  in  1  prediction made for this instruction, carried through IF/ID
ID_predicted_target  in  ADDR_W  target predicted for this instruction, carried through IF/ID
IF_ID_stall  in  1  ID held this cycle; suppresses table update
branch_mispredicted  out  1  ID resolution disagrees with the carried prediction
branch_taken  out  1  ID_is_branch & ID_actual_taken
mispredict_count  out  16  count of mispredictions since reset

Behaviour:
- Reset (rst_n=0 at rising edge, synchronous): all valid bits=0, tags=0, targets=0, counters=2'b01 (weakly not-taken), mispredict_count=0.
- Prediction outputs then read 0 combinationally, since valid=0.
- Field split for any PC: idx = PC[IDX_W:1]; tag = PC[ADDR_W-1:IDX_W+1]; PC[0] ignored.
- Lookup is purely combinational, zero latency:
  - hit = valid[idx(IF_PC)] & (tag[idx] == tag(IF_PC))
  - predicted_taken = hit & counter[idx][1]
  - predicted_target = hit ? target[idx] : 0
- Mispredict detection is combinational and independent of IF_ID_stall:
  - branch_mispredicted = ID_is_branch & ((ID_predicted_taken != ID_actual_taken) | (ID_actual_taken & ID_predicted_taken & ID_predicted_target != ID_actual_target))
  - Non-branch instructions (ID_is_branch=0) never mispredict.
- Update commit: occurs at the rising edge only when ID_is_branch & ~IF_ID_stall & rst_n. A stalled branch is re-presented and updates exactly once.
- Update on hit (valid & tag match at idx(ID_PC)):
  - Counter increments on taken, saturating at 2'b11; decrements on not-taken, saturating at 2'b00.
  - If taken, target is overwritten with ID_actual_target.
- Update on miss:
  - Taken: allocate/replace the entry with valid=1, tag=tag(ID_PC), target=ID_actual_target, counter=2'b10.
  - Not-taken: no table change.
- mispredict_count increments on every commit where branch_mispredicted=1 and saturates at 16'hFFFF.
- Read/write same cycle, same index: the lookup returns pre-update contents; the new value is visible the next cycle.
- Aliasing: different tags at the same index evict each other. There is no associativity.
- Reset asserted mid-update: reset wins and the update is discarded.

Test Plan:
- Reset, then IF_PC=16'h0010 -> predicted_taken=0, predicted_target=0, mispredict_count=0.
- Branch at ID_PC=16'h0010, taken to 16'h0040, predicted 0 -> branch_mispredicted=1, branch_taken=1, count=1. Next cycle IF_PC=16'h0010 gives predicted_taken=1, target=16'h0040.
- Same PC resolved not-taken twice -> counter 10->01->00; predicted_taken=0 after the first not-taken; the second not-taken (predicted 0) does not mispredict.
- Entry present with target 16'h0040; taken resolved to 16'h0080 with predicted_taken=1, predicted_target=16'h0040 -> branch_mispredicted=1, target becomes 16'h0080.
- ID_is_branch=1, taken, IF_ID_stall=1 for 3 cycles, then released -> table updates once, count increments once. branch_mispredicted stays 1 during the stall if the prediction was wrong.
- Aliasing: PC 16'h0010 allocated, then PC 16'h0020 (same idx 0, different tag) taken -> the lookup of 16'h0010 misses. Pulsing rst_n low mid-sequence -> all predictions 0, count 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: IF lookup and ID resolution signals of the branch predictor.
interface branch_predictor_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] IF_PC;
    logic              predicted_taken;
    logic [ADDR_W-1:0] predicted_target;
    logic [ADDR_W-1:0] ID_PC;
    logic              ID_is_branch;
    logic              ID_actual_taken;
    logic [ADDR_W-1:0] ID_actual_target;
    logic              ID_predicted_taken;
    logic [ADDR_W-1:0] ID_predicted_target;
    logic              IF_ID_stall;
    logic              branch_mispredicted;
    logic              branch_taken;
    logic [15:0]       mispredict_count;

    modport master (
        output IF_PC, ID_PC, ID_is_branch, ID_actual_taken, ID_actual_target,
               ID_predicted_taken, ID_predicted_target, IF_ID_stall,
        input  predicted_taken, predicted_target, branch_mispredicted, branch_taken,
               mispredict_count
    );

    modport slave (
        input  IF_PC, ID_PC, ID_is_branch, ID_actual_taken, ID_actual_target,
               ID_predicted_taken, ID_predicted_target, IF_ID_stall,
        output predicted_taken, predicted_target, branch_mispredicted, branch_taken,
               mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped 2-bit BHT plus BTB; combinational IF lookup,
// ID-stage mispredict detection and table update.
module branch_predictor #(
    parameter int ADDR_W      = 16,
    parameter int NUM_ENTRIES = 8
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 1;

    logic [NUM_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag    [NUM_ENTRIES];
    logic [ADDR_W-1:0]      r_target [NUM_ENTRIES];
    logic [1:0]             r_ctr    [NUM_ENTRIES];
    logic [15:0]            r_mis_cnt;

    logic [IDX_W-1:0] w_if_idx, w_id_idx;
    logic [TAG_W-1:0] w_if_tag, w_id_tag;
    logic [1:0]       w_id_ctr;
    logic             w_if_hit, w_id_hit, w_mis, w_commit, w_taken, w_unused;

    // PC[0] is always zero for 2-byte aligned instructions
    assign w_unused = &{1'b0, bus.IF_PC[0], bus.ID_PC[0]};

    assign w_if_idx = bus.IF_PC[IDX_W:1];
    assign w_if_tag = bus.IF_PC[ADDR_W-1:IDX_W+1];
    assign w_id_idx = bus.ID_PC[IDX_W:1];
    assign w_id_tag = bus.ID_PC[ADDR_W-1:IDX_W+1];
    assign w_id_ctr = r_ctr[w_id_idx];
    assign w_taken  = bus.ID_actual_taken;

    assign w_if_hit = r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
    assign w_id_hit = r_valid[w_id_idx] & (r_tag[w_id_idx] == w_id_tag);

    assign w_mis = bus.ID_is_branch &
                   ((bus.ID_predicted_taken != w_taken) |
                    (w_taken & bus.ID_predicted_taken &
                     (bus.ID_predicted_target != bus.ID_actual_target)));
    assign w_commit = bus.ID_is_branch & ~bus.IF_ID_stall;

    assign bus.predicted_taken     = w_if_hit & r_ctr[w_if_idx][1];
    assign bus.predicted_target    = w_if_hit ? r_target[w_if_idx] : '0;
    assign bus.branch_mispredicted = w_mis;
    assign bus.branch_taken        = bus.ID_is_branch & w_taken;
    assign bus.mispredict_count    = r_mis_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_mis_cnt <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_commit) begin
            if (w_id_hit) begin
                r_ctr[w_id_idx] <= w_taken ? ((w_id_ctr == 2'b11) ? 2'b11 : w_id_ctr + 2'd1)
                                           : ((w_id_ctr == 2'b00) ? 2'b00 : w_id_ctr - 2'd1);
                if (w_taken) r_target[w_id_idx] <= bus.ID_actual_target;
            end else if (w_taken) begin
                r_valid[w_id_idx]  <= 1'b1;
                r_tag[w_id_idx]    <= w_id_tag;
                r_target[w_id_idx] <= bus.ID_actual_target;
                r_ctr[w_id_idx]    <= 2'b10;
            end
            if (w_mis && r_mis_cnt != 16'hFFFF) r_mis_cnt <= r_mis_cnt + 16'd1;
        end
    end
endmodule
